uart_rx_fifo: RTL

Receive-side byte buffer that sits directly downstream of the UART receiver. It captures each byte on the receiver's one-cycle completion strobe and optionally corrects the bit order. It holds bytes in a power-of-two circular FIFO and presents them to the consumer (CPU bus bridge or command parser) over a valid/ready interface. Bytes arriving while the FIFO is full are dropped and flagged in a sticky overflow bit.

---
 rtl/uart_rx_fifo.sv | 111 +++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver. It captures one byte per rising edge of
// rx_send, can reverse the bit order, and presents bytes first-word fall-through over valid/ready.
module uart_rx_fifo #(
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned AW      = $clog2(DEPTH),
   parameter bit          REVERSE = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [7:0]    rx_data,
   input  logic          rx_send,
   output logic [7:0]    out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty,
   output logic          overflow,
   input  logic          clr_overflow
);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          overflow_q, overflow_d;
   logic          send_q;

   logic          wr;
   logic          pop;
   logic          accept;
   logic          drop;
   logic [7:0]    wr_byte;

   // send_q resets high so a strobe already asserted at reset release is ignored
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         send_q     <= 1'b1;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         send_q     <= rx_send;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         mem_q[wr_ptr_q] <= wr_byte;
      end
   end

   always_comb begin
      wr_byte = rx_data;
      if (REVERSE) begin
         for (int i = 0; i < 8; i++) begin
            wr_byte[i] = rx_data[7-i];
         end
      end
   end

   always_comb begin
      wr     = rx_send & ~send_q;
      pop    = out_valid & out_ready;
      // A pop in the same cycle frees the slot, so a full FIFO still accepts
      accept = wr & (~full | pop);
      drop   = wr & full & ~pop;
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;

      if (accept) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end

      case ({accept, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase

      // Set has priority over clear
      if (drop) begin
         overflow_d = 1'b1;
      end else if (clr_overflow) begin
         overflow_d = 1'b0;
      end
   end

   always_comb begin
      full      = (count_q == (AW+1)'(DEPTH));
      empty     = (count_q == '0);
      out_valid = ~empty;
      out_data  = mem_q[rd_ptr_q];
      count     = count_q;
      overflow  = overflow_q;
   end

endmodule
